// File: rtl/shake_pad_feeder.sv
// SHAKE input feeder: streams 32-bit message words out as rate-block words with 0x1F/0x80 padding.
// Optional SHAKE_MSG_LEN_EN macro enables the accepted-byte counter on msg_len.
module shake_pad_feeder #(
    parameter int WIN           = 32,
    parameter int RATE128_WORDS = 42,
    parameter int RATE256_WORDS = 34
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           mux256,
    input  logic [WIN-1:0] din,
    input  logic           din_valid,
    input  logic           din_last,
    input  logic [2:0]     din_bytes,
    output logic           din_ready,
    output logic [WIN-1:0] out_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           out_bof,
    output logic           out_eob,
    output logic           out_eom,
    output logic [31:0]    msg_len,
    output logic [1:0]     state_dbg
);
    // Handshake: a word moves on any rising edge where valid && ready are both high;
    // the single output register is free when empty or being drained this cycle.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MSG      = 2'd1,
        PAD_DOM  = 2'd2,
        PAD_ZERO = 2'd3
    } state_t;

    state_t         state, state_n;
    logic [5:0]     word_cnt;
    logic           rate_q;
    logic           rate_eff;
    logic [5:0]     last_idx;
    logic           at_end;
    logic           free;
    logic           accept;
    logic           load;
    logic           ld_eom;
    logic [2:0]     nb;
    logic [WIN-1:0] pad_word;
    logic [WIN-1:0] ld_data;

    // The first word of a message uses mux256 directly since it is latched on that same edge.
    assign rate_eff  = (state == IDLE) ? mux256 : rate_q;
    assign last_idx  = rate_eff ? 6'(RATE256_WORDS - 1) : 6'(RATE128_WORDS - 1);
    assign at_end    = (word_cnt == last_idx);
    assign free      = !out_valid || out_ready;
    assign din_ready = free && ((state == IDLE) || (state == MSG));
    assign accept    = din_valid && din_ready;
    assign nb        = (din_bytes > 3'd4) ? 3'd4 : din_bytes;
    assign state_dbg = state;

    always_comb begin
        pad_word = '0;
        for (int k = 0; k < 4; k++) begin
            if (3'(k) < nb)       pad_word[8*k +: 8] = din[8*k +: 8];
            else if (3'(k) == nb) pad_word[8*k +: 8] = 8'h1F;
        end
    end

    always_comb begin
        state_n = state;
        load    = 1'b0;
        ld_data = '0;
        ld_eom  = 1'b0;
        case (state)
            IDLE, MSG: begin
                if (accept) begin
                    load    = 1'b1;
                    ld_data = din;
                    state_n = MSG;
                    if (din_last) begin
                        if (nb == 3'd4) begin
                            state_n = PAD_DOM;
                        end else begin
                            ld_data = pad_word;
                            if (at_end) begin
                                ld_data[WIN-1] = 1'b1;
                                ld_eom         = 1'b1;
                                state_n        = IDLE;
                            end else begin
                                state_n = PAD_ZERO;
                            end
                        end
                    end
                end
            end
            PAD_DOM: begin
                if (free) begin
                    load    = 1'b1;
                    ld_data = WIN'(32'h0000_001F);
                    if (at_end) begin
                        ld_data[WIN-1] = 1'b1;
                        ld_eom         = 1'b1;
                        state_n        = IDLE;
                    end else begin
                        state_n = PAD_ZERO;
                    end
                end
            end
            PAD_ZERO: begin
                if (free) begin
                    load = 1'b1;
                    if (at_end) begin
                        ld_data[WIN-1] = 1'b1;
                        ld_eom         = 1'b1;
                        state_n        = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            word_cnt  <= '0;
            rate_q    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_bof   <= 1'b0;
            out_eob   <= 1'b0;
            out_eom   <= 1'b0;
        end else begin
            state <= state_n;
            if (accept && (state == IDLE)) rate_q <= mux256;
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= ld_data;
                out_bof   <= (word_cnt == 6'd0);
                out_eob   <= at_end;
                out_eom   <= ld_eom;
                word_cnt  <= at_end ? 6'd0 : word_cnt + 6'd1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef SHAKE_MSG_LEN_EN
    logic [31:0] len_q;
    logic [31:0] add_bytes;

    assign add_bytes = din_last ? {29'd0, nb} : 32'd4;
    assign msg_len   = len_q;

    always_ff @(posedge clk) begin
        if (rst)         len_q <= '0;
        else if (accept) len_q <= (state == IDLE) ? add_bytes : len_q + add_bytes;
    end
`else
    assign msg_len = '0;
`endif

endmodule

// File: tb/tb_shake_pad_feeder.sv
// Bench for shake_pad_feeder: directed and random messages scored against a byte-level padding model.
module tb_shake_pad_feeder;
    localparam int WIN = 32;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           mux256 = 1'b0;
    logic [WIN-1:0] din = '0;
    logic           din_valid = 1'b0;
    logic           din_last = 1'b0;
    logic [2:0]     din_bytes = '0;
    logic           din_ready;
    logic [WIN-1:0] out_data;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic           out_bof, out_eob, out_eom;
    logic [31:0]    msg_len;
    logic [1:0]     state_dbg;

    int checks = 0;
    int failures = 0;
    int rdy_mode = 0;   // 0: always ready, 1: random, 2: held low

    logic [WIN+2:0] exp_q[$];   // {bof, eob, eom, data}
    logic [31:0]    msg_w[$];
    int             msg_nb;
    bit             msg_rate;
    int             exp_len;
    logic [WIN+2:0] held;
    bit             hold_pend = 1'b0;

    shake_pad_feeder dut (
        .clk(clk), .rst(rst), .mux256(mux256), .din(din), .din_valid(din_valid),
        .din_last(din_last), .din_bytes(din_bytes), .din_ready(din_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_bof(out_bof), .out_eob(out_eob), .out_eom(out_eom),
        .msg_len(msg_len), .state_dbg(state_dbg)
    );

    // clock / reset
    initial forever #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (rdy_mode == 0)      out_ready = 1'b1;
        else if (rdy_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
        else                    out_ready = 1'b0;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // scoreboard: consume on handshake, verify stability while stalled
    always @(negedge clk) begin
        logic [WIN+2:0] obs;
        logic [WIN+2:0] e;
        obs = {out_bof, out_eob, out_eom, out_data};
        if (!rst && hold_pend) begin
            checks++;
            assert (out_valid === 1'b1 && obs === held) else begin
                failures++;
                $error("FAIL hold_stable obs=%h exp=%h", obs, held);
            end
        end
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $error("FAIL unexpected_word obs=%h exp=none", obs);
            end else begin
                e = exp_q.pop_front();
                assert (obs === e) else begin
                    failures++;
                    $error("FAIL out_word obs=%h exp=%h", obs, e);
                end
            end
        end
        hold_pend = !rst && out_valid && !out_ready;
        held      = obs;
    end

    // reference: pad the byte string, then slice into flagged words
    task automatic build_expected();
        logic [7:0] bytes[$];
        int r, blk, total, lim, nw;
        logic [31:0] w;
        for (int i = 0; i < msg_w.size(); i++) begin
            lim = (i == msg_w.size() - 1) ? ((msg_nb > 4) ? 4 : msg_nb) : 4;
            for (int k = 0; k < lim; k++) bytes.push_back(msg_w[i][8*k +: 8]);
        end
        exp_len = bytes.size();
        r     = msg_rate ? 34 : 42;
        blk   = 4 * r;
        total = ((exp_len + 1 + blk - 1) / blk) * blk;
        bytes.push_back(8'h1F);
        while (bytes.size() < total) bytes.push_back(8'h00);
        bytes[total-1] = bytes[total-1] | 8'h80;
        nw = total / 4;
        for (int j = 0; j < nw; j++) begin
            w = {bytes[4*j+3], bytes[4*j+2], bytes[4*j+1], bytes[4*j]};
            exp_q.push_back({(j % r) == 0, (j % r) == r - 1, j == nw - 1, w});
        end
    endtask

    // driver
    task automatic send_word(input logic [31:0] d, input logic last, input logic [2:0] nb,
                             input logic m);
        int c = 0;
        din = d; din_last = last; din_bytes = nb; mux256 = m; din_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (din_ready) break;
            c++;
            if (c > 1000) begin
                chk("din_accept_timeout", 64'(c), 64'd0);
                break;
            end
        end
        @(posedge clk); #1;
        din_valid = 1'b0;
    endtask

    task automatic run_msg(input bit gaps);
        build_expected();
        for (int i = 0; i < msg_w.size(); i++) begin
            if (i == msg_w.size() - 1)
                send_word(msg_w[i], 1'b1, 3'(msg_nb), (i == 0) ? msg_rate : 1'($urandom));
            else
                send_word(msg_w[i], 1'b0, 3'($urandom_range(0, 7)),
                          (i == 0) ? msg_rate : 1'($urandom));
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
    endtask

    task automatic wait_drain(input string tag);
        int c = 0;
        while (exp_q.size() != 0 && c < 3000) begin @(posedge clk); c++; end
        #1;
        chk(tag, 64'(exp_q.size()), 64'd0);
        repeat (3) begin @(posedge clk); #1; end
`ifdef SHAKE_MSG_LEN_EN
        chk({tag, "_msg_len"}, 64'(msg_len), 64'(exp_len));
`else
        chk({tag, "_msg_len"}, 64'(msg_len), 64'd0);
`endif
    endtask

    task automatic set_full_words(input int n, input logic [31:0] last_w, input int nb);
        msg_w.delete();
        for (int i = 0; i < n - 1; i++) msg_w.push_back($urandom);
        msg_w.push_back(last_w);
        msg_nb = nb;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_out_data"}, 64'(out_data), 64'd0);
        chk({tag, "_flags"}, 64'({out_bof, out_eob, out_eom}), 64'd0);
        chk({tag, "_msg_len"}, 64'(msg_len), 64'd0);
        chk({tag, "_din_ready"}, 64'(din_ready), 64'd1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst = 1'b0;

        // empty message, SHAKE256
        msg_w.delete(); msg_w.push_back(32'h1234_5678); msg_nb = 0; msg_rate = 1'b1;
        run_msg(1'b0); wait_drain("empty256");

        // three-byte message, SHAKE128
        msg_w.delete(); msg_w.push_back(32'hDDCC_BBAA); msg_nb = 3; msg_rate = 1'b0;
        run_msg(1'b0); wait_drain("three128");

        // exactly one full SHAKE256 block of data
        set_full_words(34, $urandom, 4); msg_rate = 1'b1;
        run_msg(1'b0); wait_drain("full_block256");

        // domain and final bits share the last byte
        set_full_words(34, 32'h4433_2211, 3); msg_rate = 1'b1;
        run_msg(1'b0); wait_drain("shared_byte256");

        // consumer stall mid-message
        set_full_words(10, $urandom, 2); msg_rate = 1'b0;
        fork
            run_msg(1'b0);
            begin
                repeat (4) @(posedge clk);
                rdy_mode = 2;
                repeat (5) begin
                    @(negedge clk);
                    chk("stall_din_ready", 64'(din_ready), 64'd0);
                    chk("stall_out_valid", 64'(out_valid), 64'd1);
                end
                rdy_mode = 0;
            end
        join
        wait_drain("stall");

        // random messages with random backpressure and input gaps
        rdy_mode = 1;
        for (int t = 0; t < 8; t++) begin
            set_full_words($urandom_range(1, 45), $urandom, $urandom_range(0, 7));
            msg_rate = 1'($urandom);
            run_msg(1'b1); wait_drain("random");
        end
        rdy_mode = 0;

        // reset while padding zeros
        msg_w.delete(); msg_w.push_back(32'h0000_0077); msg_nb = 1; msg_rate = 1'b0;
        run_msg(1'b0);
        repeat (5) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        check_reset_state("mid_pad_reset");
        msg_w.delete(); msg_w.push_back(32'h0000_00AB); msg_nb = 1; msg_rate = 1'b0;
        run_msg(1'b0); wait_drain("after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout obs=running exp=finished");
        $fatal(1, "global timeout");
    end
endmodule
